// File: rtl/adder_serial_n.sv
// adder_serial_n: multi-cycle N-bit adder/subtractor.
// Processes K bits per cycle through a K-slice ripple chain with a registered
// carry, walking the operands LSB chunk first.  Handshakes on valid/ready at
// both the input and output side.
module adder_serial_n #(
   parameter int N = 32,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int CHUNKS = N / K;
   localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CHUNKS - 1);
   localparam logic [N-1:0]     CHUNK_MASK = N'({K{1'b1}});

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             init_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [N-1:0]     sum_q, sum_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             last_chunk;
   logic [31:0]      shamt;
   logic [K-1:0]     a_chunk, b_chunk, s_chunk;
   logic [K:0]       c_chain;

   assign accept     = i_valid && i_ready;
   assign last_chunk = (cnt_q == LAST_CNT);

   // State register; init_q keeps i_ready low until the first edge out of reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)     state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    if (o_ready)    state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from registered state only
   always_comb begin
      i_ready = init_q && (state_q == IDLE);
      o_valid = (state_q == DONE);
   end

   // K-slice ripple chain on the current chunk; c_chain[K-1] is the carry into
   // the top bit of the chunk, which on the last chunk is the carry into bit N-1
   always_comb begin
      shamt      = 32'(cnt_q) * 32'(K);
      a_chunk    = K'(a_q >> shamt);
      b_chunk    = K'(b_q >> shamt);
      s_chunk    = '0;
      c_chain    = '0;
      c_chain[0] = carry_q;
      for (int i = 0; i < K; i++) begin
         s_chunk[i]   = a_chunk[i] ^ b_chunk[i] ^ c_chain[i];
         c_chain[i+1] = (a_chunk[i] & b_chunk[i]) |
                        (c_chain[i] & (a_chunk[i] ^ b_chunk[i]));
      end
   end

   // Datapath next-state: latch operands on accept, fold one chunk per RUN cycle
   always_comb begin
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub ? ~c_in : c_in;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         sum_d   = (sum_q & ~(CHUNK_MASK << shamt)) | ((N'(s_chunk)) << shamt);
         carry_d = c_chain[K];
         cnt_d   = cnt_q + 1'b1;
         if (last_chunk) begin
            c_out_d = c_chain[K];
            ovf_d   = c_chain[K] ^ c_chain[K-1];
            cnt_d   = '0;
         end
      end
   end

   // Counter and result registers, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   // Operand and running-carry registers; only meaningful after an accept
   always_ff @(posedge clk) begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
   end

   assign sum      = sum_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;

endmodule
